alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Sequential decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts opcode bytes from the fetch unit and tracks the 0xCB prefix.
- Obtains operands from the register file, the immediate byte stream, or memory at (HL).
- Issues one single-cycle, fully registered command per instruction to the ALU: op/src/dest/src_data/dest_data/size/ext/misc.

Parameters:
- A_IDX, 3'b111, register index of accumulator A; driven on alu_dest for base ALU/misc ops.
- HL_IDX, 3'b110, register-field encoding meaning the (HL) memory operand.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- op_valid  input  1  fetch presents op_byte.
- op_byte  input  8  opcode, prefix, or immediate byte.
- op_ready  output  1  block can accept a byte this cycle.
- reg_rd_idx  output  3  register-file read index (async read).
- reg_rd_data  input  8  register-file data for reg_rd_idx, same cycle.
- reg_a  input  8  current A register value.
- mem_rd_req  output  1  read request for byte at (HL).
- mem_rd_valid  input  1  memory read data valid.
- mem_rd_data  input  8  memory read data.
- alu_valid  output  1  one-cycle command strobe to ALU.
- alu_op  output  3  ALU op field.
- alu_src  output  3  src field (bit number for BIT/RES/SET).
- alu_dest  output  3  dest field.
- alu_src_data  output  8  source operand.
- alu_dest_data  output  8  destination operand.
- alu_size  output  1  always 0 (8-bit).
- alu_ext  output  1  CB-extension instruction.
- alu_misc  output  1  misc group.
- unsupported  output  1  one-cycle pulse: accepted byte not handled by ALU path.

Behaviour:
- Reset: state IDLE; op_ready=1; mem_rd_req, alu_valid, unsupported = 0; all alu_* fields and reg_rd_idx = 0; CB flag cleared. Reset mid-instruction discards pending prefix, immediate, or memory read, and drops mem_rd_req the next cycle.
- Handshake: byte consumed only when op_valid && op_ready. op_ready=1 only in IDLE, CB_WAIT, IMM_WAIT. op_valid is ignored elsewhere.
- States: IDLE, CB_WAIT, IMM_WAIT, REG_RD, MEM_WAIT, ISSUE.
- IDLE decode of accepted byte b:
  - 0x80-0xBF: op=b[5:3], src=b[2:0], dest=A_IDX, ext=0, misc=0. If src==HL_IDX go MEM_WAIT, else REG_RD.
  - 11xxx110 (0xC6..0xFE): op=b[5:3], src=HL_IDX, dest=A_IDX. Go IMM_WAIT.
  - 0x27/0x2F/0x37/0x3F: op={1'b0,b[4:3]}, misc=1, ext=0, src=dest=A_IDX, src_data=dest_data=reg_a. Go ISSUE.
  - 0xCB: go CB_WAIT.
  - Anything else: unsupported=1 next cycle; stay IDLE.
- CB_WAIT, accepted byte c:
  - c[7:6]==00: ext=1, misc=0, op=c[5:3], src=dest=c[2:0].
  - Otherwise: ext=1, misc=1, op={1'b0,c[7:6]}, src=c[5:3], dest=c[2:0], src_data={5'b0,c[5:3]}.
  - Then MEM_WAIT if c[2:0]==HL_IDX, else REG_RD. A second 0xCB is decoded as a normal CB-table byte (SET 1,E), not as a prefix.
- IMM_WAIT: accepted byte becomes src_data; dest_data=reg_a; go ISSUE.
- REG_RD (1 cycle): reg_rd_idx=latched register field; sample reg_rd_data.
  - Base ops: src_data=reg_rd_data, dest_data=reg_a.
  - CB arithmetic: src_data=dest_data=reg_rd_data.
  - BIT/RES/SET: dest_data=reg_rd_data.
  - Go ISSUE.
- MEM_WAIT: mem_rd_req=1 from state entry until the cycle mem_rd_valid is seen (valid in the first cycle is accepted). mem_rd_data is substituted exactly as reg_rd_data in REG_RD. mem_rd_req=0 the cycle after. Go ISSUE. No timeout.
- ISSUE (1 cycle): alu_valid=1 with all fields stable; next state IDLE (op_ready=1 the following cycle). alu_* fields hold their values after alu_valid drops.
- Latency (acceptance edge to alu_valid):
  - Register operand: 2 cycles.
  - Misc: 1 cycle.
  - Immediate: 1 cycle after immediate-byte acceptance.
  - Memory: 1 cycle after mem_rd_valid.
- CB prefix and immediate stalls: op_valid low simply holds state indefinitely.

Test Plan:
- reg_a=0x12, B(0)=0x34; byte 0x80 -> 2 cycles later alu_valid=1, op=0, src=0, dest=7, src_data=0x34, dest_data=0x12, ext=0, misc=0.
- Bytes 0xCB, 0x7C, H(4)=0x80 -> alu_valid, ext=1, misc=1, op=1 (BIT), src=7, dest=4, src_data=0x07, dest_data=0x80.
- Byte 0xE6 then op_valid low 3 cycles then 0x0F -> op_ready held 1, one alu_valid with op=4, src_data=0x0F, dest_data=reg_a.
- Byte 0xAE; mem_rd_valid after 4 cycles with 0x55 -> mem_rd_req high exactly until valid cycle; op=5, src=6, src_data=0x55; op_ready=0 throughout.
- Byte 0x00 -> unsupported single pulse, no alu_valid. Byte 0x2F -> misc=1, op=1, src_data=dest_data=reg_a.
- rst asserted in CB_WAIT and separately mid MEM_WAIT -> next cycle IDLE, mem_rd_req=0; following 0x06-style CB byte (e.g. 0x06) is treated as unsupported, not RLC (HL).

Source files
------------

// File: rtl/alu_issue_if.sv
// Decode-stage bus bundle: fetch byte handshake, register-file and (HL) memory
// reads, and the registered ALU command.
interface alu_issue_if;
    logic       op_valid;
    logic [7:0] op_byte;
    logic       op_ready;

    logic [2:0] reg_rd_idx;
    logic [7:0] reg_rd_data;
    logic [7:0] reg_a;

    logic       mem_rd_req;
    logic       mem_rd_valid;
    logic [7:0] mem_rd_data;

    logic       alu_valid;
    logic [2:0] alu_op;
    logic [2:0] alu_src;
    logic [2:0] alu_dest;
    logic [7:0] alu_src_data;
    logic [7:0] alu_dest_data;
    logic       alu_size;
    logic       alu_ext;
    logic       alu_misc;
    logic       unsupported;

    modport slave (
        input  op_valid, op_byte, reg_rd_data, reg_a, mem_rd_valid, mem_rd_data,
        output op_ready, reg_rd_idx, mem_rd_req,
        output alu_valid, alu_op, alu_src, alu_dest, alu_src_data, alu_dest_data,
        output alu_size, alu_ext, alu_misc, unsupported
    );

    modport master (
        output op_valid, op_byte, reg_rd_data, reg_a, mem_rd_valid, mem_rd_data,
        input  op_ready, reg_rd_idx, mem_rd_req,
        input  alu_valid, alu_op, alu_src, alu_dest, alu_src_data, alu_dest_data,
        input  alu_size, alu_ext, alu_misc, unsupported
    );
endinterface

// File: rtl/alu_issue.sv
// Decode/operand-fetch stage in front of the 8-bit ALU: tracks the CB prefix,
// gathers register/immediate/(HL) operands and issues one registered command.
//
// state      | meaning
// IDLE       | waiting for an opcode or prefix byte
// CB_WAIT    | CB prefix seen, waiting for the extension byte
// IMM_WAIT   | immediate ALU op decoded, waiting for the immediate byte
// REG_RD     | one cycle reading the register file
// MEM_WAIT   | requesting (HL) until memory data arrives
// ISSUE      | alu_valid high for one cycle
module alu_issue #(
    parameter logic [2:0] A_IDX  = 3'b111,
    parameter logic [2:0] HL_IDX = 3'b110
) (
    input logic       clk,
    input logic       rst,
    alu_issue_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CB_WAIT, S_IMM_WAIT, S_REG_RD, S_MEM_WAIT, S_ISSUE
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] src_q, src_d;
    logic [2:0] dest_q, dest_d;
    logic [7:0] src_data_q, src_data_d;
    logic [7:0] dest_data_q, dest_data_d;
    logic       ext_q, ext_d;
    logic       misc_q, misc_d;
    logic [2:0] rd_idx_q, rd_idx_d;
    logic       unsup_q, unsup_d;
    logic [7:0] b;
    logic [7:0] opnd;

    assign b = bus.op_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            src_q       <= '0;
            dest_q      <= '0;
            src_data_q  <= '0;
            dest_data_q <= '0;
            ext_q       <= 1'b0;
            misc_q      <= 1'b0;
            rd_idx_q    <= '0;
            unsup_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dest_q      <= dest_d;
            src_data_q  <= src_data_d;
            dest_data_q <= dest_data_d;
            ext_q       <= ext_d;
            misc_q      <= misc_d;
            rd_idx_q    <= rd_idx_d;
            unsup_q     <= unsup_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dest_d      = dest_q;
        src_data_d  = src_data_q;
        dest_data_d = dest_data_q;
        ext_d       = ext_q;
        misc_d      = misc_q;
        rd_idx_d    = rd_idx_q;
        unsup_d     = 1'b0;
        opnd        = (state_q == S_MEM_WAIT) ? bus.mem_rd_data : bus.reg_rd_data;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    if (b[7:6] == 2'b10) begin
                        op_d     = b[5:3];
                        src_d    = b[2:0];
                        dest_d   = A_IDX;
                        ext_d    = 1'b0;
                        misc_d   = 1'b0;
                        rd_idx_d = b[2:0];
                        state_d  = (b[2:0] == HL_IDX) ? S_MEM_WAIT : S_REG_RD;
                    end else if (b[7:6] == 2'b11 && b[2:0] == 3'b110) begin
                        op_d    = b[5:3];
                        src_d   = HL_IDX;
                        dest_d  = A_IDX;
                        ext_d   = 1'b0;
                        misc_d  = 1'b0;
                        state_d = S_IMM_WAIT;
                    end else if (b == 8'h27 || b == 8'h2F || b == 8'h37 || b == 8'h3F) begin
                        op_d        = {1'b0, b[4:3]};
                        src_d       = A_IDX;
                        dest_d      = A_IDX;
                        src_data_d  = bus.reg_a;
                        dest_data_d = bus.reg_a;
                        ext_d       = 1'b0;
                        misc_d      = 1'b1;
                        state_d     = S_ISSUE;
                    end else if (b == 8'hCB) begin
                        state_d = S_CB_WAIT;
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
            end
            S_CB_WAIT: begin
                // Any byte here is a CB-table entry, including another 0xCB.
                if (bus.op_valid) begin
                    ext_d    = 1'b1;
                    dest_d   = b[2:0];
                    rd_idx_d = b[2:0];
                    if (b[7:6] == 2'b00) begin
                        misc_d = 1'b0;
                        op_d   = b[5:3];
                        src_d  = b[2:0];
                    end else begin
                        misc_d     = 1'b1;
                        op_d       = {1'b0, b[7:6]};
                        src_d      = b[5:3];
                        src_data_d = {5'b0, b[5:3]};
                    end
                    state_d = (b[2:0] == HL_IDX) ? S_MEM_WAIT : S_REG_RD;
                end
            end
            S_IMM_WAIT: begin
                if (bus.op_valid) begin
                    src_data_d  = b;
                    dest_data_d = bus.reg_a;
                    state_d     = S_ISSUE;
                end
            end
            S_REG_RD, S_MEM_WAIT: begin
                if (state_q == S_REG_RD || bus.mem_rd_valid) begin
                    if (!ext_q) begin
                        src_data_d  = opnd;
                        dest_data_d = bus.reg_a;
                    end else if (!misc_q) begin
                        src_data_d  = opnd;
                        dest_data_d = opnd;
                    end else begin
                        dest_data_d = opnd;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready      = (state_q == S_IDLE) || (state_q == S_CB_WAIT) || (state_q == S_IMM_WAIT);
        bus.mem_rd_req    = (state_q == S_MEM_WAIT);
        bus.alu_valid     = (state_q == S_ISSUE);
        bus.reg_rd_idx    = rd_idx_q;
        bus.alu_op        = op_q;
        bus.alu_src       = src_q;
        bus.alu_dest      = dest_q;
        bus.alu_src_data  = src_data_q;
        bus.alu_dest_data = dest_data_q;
        bus.alu_size      = 1'b0;
        bus.alu_ext       = ext_q;
        bus.alu_misc      = misc_q;
        bus.unsupported   = unsup_q;
    end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: instruction-level model feeding an expected-command
// queue, per-cycle command checker, and directed timing/literal checks.
module tb_alu_issue;
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] src;
        logic [2:0] dest;
        logic [7:0] sd;
        logic [7:0] dd;
        logic       ext;
        logic       misc;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus_if();
    alu_issue dut (.clk(clk), .rst(rst), .bus(bus_if));

    logic [7:0] regs [8];
    logic [7:0] mem_byte = 8'h00;
    int         mem_delay = 0;
    int         mem_cnt = 0;
    cmd_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_unsup = 0;
    int         seen_unsup = 0;

    assign bus_if.reg_rd_data = regs[bus_if.reg_rd_idx];
    assign bus_if.reg_a       = regs[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkc(input string name, input cmd_t act, input cmd_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got op=%0d src=%0d dest=%0d sd=%h dd=%h ext=%0b misc=%0b expected op=%0d src=%0d dest=%0d sd=%h dd=%h ext=%0b misc=%0b",
                     name, act.op, act.src, act.dest, act.sd, act.dd, act.ext, act.misc,
                     exp.op, exp.src, exp.dest, exp.sd, exp.dd, exp.ext, exp.misc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dest,
                                input logic [7:0] sd, input logic [7:0] dd, input logic ext, input logic misc);
        cmd_t c;
        c.op = op; c.src = src; c.dest = dest; c.sd = sd; c.dd = dd; c.ext = ext; c.misc = misc;
        return c;
    endfunction

    function automatic cmd_t cur();
        return mk(bus_if.alu_op, bus_if.alu_src, bus_if.alu_dest, bus_if.alu_src_data,
                  bus_if.alu_dest_data, bus_if.alu_ext, bus_if.alu_misc);
    endfunction

    function automatic logic two_byte(input logic [7:0] b0);
        return (b0 == 8'hCB) || (b0[7:6] == 2'b11 && b0[2:0] == 3'd6);
    endfunction

    // Instruction-level result: what the ALU must be told for this opcode sequence.
    function automatic cmd_t model(input logic [7:0] b0, input logic [7:0] b1);
        logic [2:0] r;
        logic [7:0] v;
        logic [7:0] a;
        a = regs[7];
        if (b0 == 8'hCB) begin
            r = b1[2:0];
            v = (r == 3'd6) ? mem_byte : regs[r];
            if (b1[7:6] == 2'b00) return mk(b1[5:3], r, r, v, v, 1'b1, 1'b0);
            return mk({1'b0, b1[7:6]}, b1[5:3], r, {5'b0, b1[5:3]}, v, 1'b1, 1'b1);
        end
        if (b0[7:6] == 2'b10) begin
            r = b0[2:0];
            v = (r == 3'd6) ? mem_byte : regs[r];
            return mk(b0[5:3], r, 3'd7, v, a, 1'b0, 1'b0);
        end
        if (two_byte(b0)) return mk(b0[5:3], 3'd6, 3'd7, b1, a, 1'b0, 1'b0);
        return mk({1'b0, b0[4:3]}, 3'd7, 3'd7, a, a, 1'b0, 1'b1);
    endfunction

    // Memory responder: data valid once the request has been up for mem_delay cycles.
    initial begin
        bus_if.mem_rd_valid = 1'b0;
        bus_if.mem_rd_data  = 8'h00;
        forever begin
            @(posedge clk); #2;
            bus_if.mem_rd_valid = 1'b0;
            if (bus_if.mem_rd_req) begin
                if (mem_cnt >= mem_delay) begin
                    bus_if.mem_rd_valid = 1'b1;
                    bus_if.mem_rd_data  = mem_byte;
                    mem_cnt = 0;
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        cmd_t e;
        if (bus_if.alu_valid) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_alu_valid", bus_if.alu_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chkc("alu_cmd", cur(), e);
            end
            chk1("alu_size", bus_if.alu_size, 1'b0);
        end
        if (bus_if.unsupported) seen_unsup++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus_if.op_valid = 1'b1;
        bus_if.op_byte  = b;
        while (!bus_if.op_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk1("op_ready_timeout", bus_if.op_ready, 1'b1);
        @(posedge clk); #1;
        bus_if.op_valid = 1'b0;
        bus_if.op_byte  = 8'h00;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chki("issue_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(model(b0, b1));
        send_byte(b0);
        if (two_byte(b0)) send_byte(b1);
        wait_drain();
    endtask

    logic [7:0] vb0 [11] = '{8'hB9, 8'hCB, 8'hCB, 8'hFE, 8'h27, 8'h37, 8'h3F, 8'h96, 8'hCB, 8'hCB, 8'hCB};
    logic [7:0] vb1 [11] = '{8'h00, 8'h11, 8'h06, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC6, 8'h46, 8'h38};
    logic [7:0] vmem[11] = '{8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h10, 8'hF0, 8'h00};
    int         vdly[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.op_valid = 1'b0;
        bus_if.op_byte  = 8'h00;
        regs[0] = 8'h34; regs[1] = 8'h9C; regs[2] = 8'h21; regs[3] = 8'h5A;
        regs[4] = 8'h80; regs[5] = 8'h0E; regs[6] = 8'hEE; regs[7] = 8'h12;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_op_ready", bus_if.op_ready, 1'b1);
        chk1("rst_alu_valid", bus_if.alu_valid, 1'b0);
        chk1("rst_mem_rd_req", bus_if.mem_rd_req, 1'b0);
        chk1("rst_unsupported", bus_if.unsupported, 1'b0);
        chki("rst_reg_rd_idx", int'(bus_if.reg_rd_idx), 0);
        chkc("rst_fields", cur(), mk(3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD A,B: two cycles from acceptance to alu_valid
        exp_q.push_back(model(8'h80, 8'h00));
        send_byte(8'h80);
        chk1("t1_lat1", bus_if.alu_valid, 1'b0);
        @(posedge clk); #1;
        chk1("t1_lat2", bus_if.alu_valid, 1'b1);
        wait_drain();
        chkc("t1_literal", cur(), mk(3'd0, 3'd0, 3'd7, 8'h34, 8'h12, 1'b0, 1'b0));

        // BIT 7,H
        run_instr(8'hCB, 8'h7C);
        chkc("t2_literal", cur(), mk(3'd1, 3'd7, 3'd4, 8'h07, 8'h80, 1'b1, 1'b1));

        // AND n with a stalled immediate
        exp_q.push_back(model(8'hE6, 8'h0F));
        send_byte(8'hE6);
        for (int i = 0; i < 3; i++) begin
            chk1("t3_ready_hold", bus_if.op_ready, 1'b1);
            chk1("t3_no_issue", bus_if.alu_valid, 1'b0);
            @(posedge clk); #1;
        end
        send_byte(8'h0F);
        chk1("t3_lat", bus_if.alu_valid, 1'b1);
        wait_drain();
        chkc("t3_literal", cur(), mk(3'd4, 3'd6, 3'd7, 8'h0F, 8'h12, 1'b0, 1'b0));

        // XOR (HL), memory answers in the fourth request cycle
        mem_byte  = 8'h55;
        mem_delay = 3;
        exp_q.push_back(model(8'hAE, 8'h00));
        send_byte(8'hAE);
        for (int i = 0; i < 4; i++) begin
            chk1("t4_req_high", bus_if.mem_rd_req, 1'b1);
            chk1("t4_ready_low", bus_if.op_ready, 1'b0);
            chk1("t4_no_issue", bus_if.alu_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk1("t4_req_drop", bus_if.mem_rd_req, 1'b0);
        chk1("t4_issue", bus_if.alu_valid, 1'b1);
        wait_drain();
        chkc("t4_literal", cur(), mk(3'd5, 3'd6, 3'd7, 8'h55, 8'h12, 1'b0, 1'b0));
        mem_delay = 0;

        // Unsupported byte, then CPL
        exp_unsup++;
        send_byte(8'h00);
        chk1("t5_unsup_pulse", bus_if.unsupported, 1'b1);
        @(posedge clk); #1;
        chk1("t5_unsup_single", bus_if.unsupported, 1'b0);
        chk1("t5_no_issue", bus_if.alu_valid, 1'b0);
        run_instr(8'h2F, 8'h00);
        chkc("t5_literal", cur(), mk(3'd1, 3'd7, 3'd7, 8'h12, 8'h12, 1'b0, 1'b1));

        // Second CB after prefix is SET 1,E
        run_instr(8'hCB, 8'hCB);
        chkc("t_cbcb_literal", cur(), mk(3'd3, 3'd1, 3'd3, 8'h01, 8'h5A, 1'b1, 1'b1));

        for (int i = 0; i < 11; i++) begin
            mem_byte  = vmem[i];
            mem_delay = vdly[i];
            run_instr(vb0[i], vb1[i]);
        end
        mem_delay = 0;

        // Reset while waiting for the CB byte: prefix is forgotten
        send_byte(8'hCB);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("t6_cb_rst_ready", bus_if.op_ready, 1'b1);
        chk1("t6_cb_rst_req", bus_if.mem_rd_req, 1'b0);
        rst = 1'b0;
        exp_unsup++;
        send_byte(8'h06);
        chk1("t6_cb_unsup", bus_if.unsupported, 1'b1);
        @(posedge clk); #1;
        chk1("t6_cb_no_issue", bus_if.alu_valid, 1'b0);

        // Reset in the middle of a memory wait
        mem_delay = 50;
        send_byte(8'hAE);
        @(posedge clk); #1;
        chk1("t6_mem_req", bus_if.mem_rd_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("t6_mem_rst_req", bus_if.mem_rd_req, 1'b0);
        chk1("t6_mem_rst_ready", bus_if.op_ready, 1'b1);
        rst = 1'b0;
        mem_delay = 0;
        exp_unsup++;
        send_byte(8'h06);
        chk1("t6_mem_unsup", bus_if.unsupported, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        chki("unsupported_count", seen_unsup, exp_unsup);
        chki("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
